ad366x_deser: RTL and testbench



---
 rtl/ad366x_deser.sv | 174 +++++++++++++++++
 tb/tb_ad366x_deser.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad366x_deser.sv
// ad366x_deser: two-lane AD366x-style serial ADC deserializer with frame alignment and lock tracking.
// Define AD366X_PAD_CHECK_EN to build the pad-bit checker; otherwise pad_err_o is tied low.
module ad366x_deser #(
  parameter int LW       = 2,
  parameter int LOCK_CNT = 4,
  parameter int MISS_MAX = 2,
  parameter int ECW      = 16
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic           fr_i,
  input  logic [LW-1:0]  da_i,
  input  logic [LW-1:0]  db_i,
  input  logic           clr_i,
  output logic [13:0]    dat_a_o,
  output logic [13:0]    dat_b_o,
  output logic           dat_vld_o,
  output logic           lock_o,
  output logic [ECW-1:0] err_cnt_o,
  output logic           pad_err_o
);
  localparam int PW = 16 / LW;
  localparam int GW = (PW > 1) ? $clog2(PW) : 1;
  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(MISS_MAX + 1);
  localparam logic [GW-1:0] G_LAST = GW'(PW - 1);
  localparam logic [CW-1:0] C_LOCK = CW'(LOCK_CNT);
  localparam logic [MW-1:0] M_MAX  = MW'(MISS_MAX);

  typedef enum logic [1:0] {HUNT = 2'd0, CHECK = 2'd1, LOCK = 2'd2} state_t;

  state_t         r_state, w_state_nx;
  logic [GW-1:0]  r_gcnt, w_gcnt_nx, w_gcnt_inc;
  logic [CW-1:0]  r_good, w_good_nx;
  logic [MW-1:0]  r_miss, w_miss_nx;
  logic           r_fr_q, w_trans, w_at_start, w_err_inc;
  logic [15:0]    r_sr_a, r_sr_b;
  logic           r_pend;

  // Alignment next-state: HUNT waits for an edge, CHECK counts on-time edges, LOCK tolerates misses
  always_comb begin
    w_trans    = fr_i ^ r_fr_q;
    w_at_start = (r_gcnt == {GW{1'b0}});
    w_gcnt_inc = (r_gcnt == G_LAST) ? {GW{1'b0}} : r_gcnt + GW'(1);
    w_state_nx = r_state;
    w_gcnt_nx  = w_gcnt_inc;
    w_good_nx  = r_good;
    w_miss_nx  = r_miss;
    w_err_inc  = 1'b0;
    case (r_state)
      HUNT: begin
        if (w_trans) begin
          w_gcnt_nx  = GW'(1);
          w_good_nx  = {CW{1'b0}};
          w_state_nx = CHECK;
        end else begin
          w_gcnt_nx  = {GW{1'b0}};
        end
      end
      CHECK: begin
        if (w_trans && w_at_start) begin
          w_good_nx = r_good + CW'(1);
          if (w_good_nx == C_LOCK) begin
            w_state_nx = LOCK;
            w_miss_nx  = {MW{1'b0}};
          end else begin
            w_state_nx = CHECK;
          end
        end else if (w_trans || w_at_start) begin
          w_state_nx = HUNT;
        end else begin
          w_state_nx = CHECK;
        end
      end
      LOCK: begin
        if (w_trans && w_at_start) begin
          w_miss_nx = {MW{1'b0}};
        end else if (w_trans || w_at_start) begin
          w_err_inc = 1'b1;
          w_miss_nx = r_miss + MW'(1);
          if (w_miss_nx == M_MAX) begin
            w_state_nx = HUNT;
            w_miss_nx  = {MW{1'b0}};
          end else begin
            w_state_nx = LOCK;
          end
        end else begin
          w_miss_nx = r_miss;
        end
      end
      default: begin
        w_state_nx = HUNT;
        w_gcnt_nx  = {GW{1'b0}};
      end
    endcase
  end

  // Alignment state, counters and registered lock flag
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= HUNT;
      r_gcnt  <= {GW{1'b0}};
      r_good  <= {CW{1'b0}};
      r_miss  <= {MW{1'b0}};
      r_fr_q  <= 1'b0;
      lock_o  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_gcnt  <= w_gcnt_nx;
      r_good  <= w_good_nx;
      r_miss  <= w_miss_nx;
      r_fr_q  <= fr_i;
      lock_o  <= (w_state_nx == LOCK);
    end
  end

  // Lane shift registers; after the last group is shifted in they hold the full 16-bit word
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sr_a <= 16'h0000;
      r_sr_b <= 16'h0000;
    end else begin
      r_sr_a <= {r_sr_a[15-LW:0], da_i};
      r_sr_b <= {r_sr_b[15-LW:0], db_i};
    end
  end

  // Saturating mismatch counter; clear has priority over a same-cycle increment
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      err_cnt_o <= {ECW{1'b0}};
    end else if (clr_i) begin
      err_cnt_o <= {ECW{1'b0}};
    end else if (w_err_inc && (err_cnt_o != {ECW{1'b1}})) begin
      err_cnt_o <= err_cnt_o + ECW'(1);
    end else begin
      err_cnt_o <= err_cnt_o;
    end
  end

  // Word output: r_pend marks a completed word, which is presented one edge later
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_pend    <= 1'b0;
      dat_vld_o <= 1'b0;
      dat_a_o   <= 14'h0000;
      dat_b_o   <= 14'h0000;
    end else begin
      r_pend    <= (r_state == LOCK) && (r_gcnt == G_LAST);
      dat_vld_o <= r_pend;
      if (r_pend) begin
        dat_a_o <= r_sr_a[15:2];
        dat_b_o <= r_sr_b[15:2];
      end else begin
        dat_a_o <= dat_a_o;
        dat_b_o <= dat_b_o;
      end
    end
  end

`ifdef AD366X_PAD_CHECK_EN
  // Pad bits of an emitted word must be zero on both lanes
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pad_err_o <= 1'b0;
    end else begin
      pad_err_o <= r_pend && ((r_sr_a[1:0] != 2'b00) || (r_sr_b[1:0] != 2'b00));
    end
  end
`else
  assign pad_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ad366x_deser.sv
// Randomized scoreboard bench for ad366x_deser; a second instance with a 3-bit error counter
// exercises saturation. The reference model tracks frame phase arithmetically from the anchor edge.
module tb_ad366x_deser;
  localparam int LW       = 2;
  localparam int PW       = 16 / LW;
  localparam int LOCK_CNT = 4;
  localparam int MISS_MAX = 2;
  localparam int M_HUNT   = 0;
  localparam int M_CHK    = 1;
  localparam int M_LOCK   = 2;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic          fr_i = 1'b0;
  logic [LW-1:0] da_i = '0;
  logic [LW-1:0] db_i = '0;
  logic          clr_i = 1'b0;
  logic [13:0]   dat_a_o, dat_b_o, s_dat_a, s_dat_b;
  logic          dat_vld_o, lock_o, pad_err_o, s_vld, s_lock, s_pad;
  logic [15:0]   err_cnt_o;
  logic [2:0]    s_err;

  ad366x_deser #(.LW(LW), .LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX), .ECW(16)) u_dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .fr_i(fr_i), .da_i(da_i), .db_i(db_i), .clr_i(clr_i),
    .dat_a_o(dat_a_o), .dat_b_o(dat_b_o), .dat_vld_o(dat_vld_o), .lock_o(lock_o),
    .err_cnt_o(err_cnt_o), .pad_err_o(pad_err_o));

  ad366x_deser #(.LW(LW), .LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX), .ECW(3)) u_dut_sat (
    .clk_i(clk_i), .rstn_i(rstn_i), .fr_i(fr_i), .da_i(da_i), .db_i(db_i), .clr_i(clr_i),
    .dat_a_o(s_dat_a), .dat_b_o(s_dat_b), .dat_vld_o(s_vld), .lock_o(s_lock),
    .err_cnt_o(s_err), .pad_err_o(s_pad));

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          due;
    logic [13:0] a;
    logic [13:0] b;
    logic        pad;
  } exp_t;

  exp_t          sb_q[$];
  logic [LW-1:0] hist_a[$];
  logic [LW-1:0] hist_b[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int m_mode = M_HUNT, m_anchor = 0, m_good = 0, m_miss = 0, m_err16 = 0, m_err3 = 0;
  logic m_fr_q = 1'b0;
  logic [13:0] m_last_a = 14'h0, m_last_b = 14'h0;
  logic src_fr = 1'b0;
  int lock_rise_cyc = -1, first_vld_cyc = -1;
  logic [13:0] first_a = 14'h0, first_b = 14'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic m_reset();
    m_mode = M_HUNT; m_anchor = 0; m_good = 0; m_miss = 0; m_err16 = 0; m_err3 = 0;
    m_fr_q = 1'b0; m_last_a = 14'h0; m_last_b = 14'h0;
    sb_q.delete(); hist_a.delete(); hist_b.delete();
    src_fr = 1'b0; fr_i = 1'b0; clr_i = 1'b0;
  endtask

  // Reference model: phase = (edge - anchor) mod PW, evaluated at each clock edge
  task automatic model(input logic fr, input logic [LW-1:0] a, input logic [LW-1:0] b, input logic clr);
    bit trans, boundary, ok, bad, mism;
    int ph;
    logic [15:0] wa, wb;
    exp_t e;
    trans = (fr != m_fr_q);
    m_fr_q = fr;
    hist_a.push_back(a); hist_b.push_back(b);
    if (hist_a.size() > PW) begin hist_a.delete(0); hist_b.delete(0); end
    ph = (cyc - m_anchor) % PW;
    boundary = (ph == 0);
    ok = trans && boundary;
    bad = (trans != boundary);
    mism = 0;
    if (m_mode == M_LOCK && ph == PW - 1) begin
      wa = 16'h0; wb = 16'h0;
      for (int i = 0; i < PW; i++) begin
        wa = (wa << LW) | 16'(hist_a[i]);
        wb = (wb << LW) | 16'(hist_b[i]);
      end
      e.due = cyc + 1; e.a = wa[15:2]; e.b = wb[15:2];
`ifdef AD366X_PAD_CHECK_EN
      e.pad = (wa[1:0] != 2'b00) || (wb[1:0] != 2'b00);
`else
      e.pad = 1'b0;
`endif
      sb_q.push_back(e);
    end
    if (m_mode == M_HUNT) begin
      if (trans) begin m_anchor = cyc; m_good = 0; m_mode = M_CHK; end
    end else if (m_mode == M_CHK) begin
      if (ok) begin
        m_good++;
        if (m_good == LOCK_CNT) begin m_mode = M_LOCK; m_miss = 0; end
      end else if (bad) m_mode = M_HUNT;
    end else begin
      if (ok) m_miss = 0;
      else if (bad) begin
        mism = 1; m_miss++;
        if (m_miss == MISS_MAX) begin m_mode = M_HUNT; m_miss = 0; end
      end
    end
    if (clr) begin m_err16 = 0; m_err3 = 0; end
    else if (mism) begin
      if (m_err16 < 65535) m_err16++;
      if (m_err3 < 7) m_err3++;
    end
  endtask

  task automatic step(input logic fr, input logic [LW-1:0] a, input logic [LW-1:0] b, input logic clr);
    fr_i = fr; da_i = a; db_i = b; clr_i = clr;
    @(posedge clk_i);
    cyc++;
    model(fr, a, b, clr);
    #1;
  endtask

  task automatic send_word_n(input logic [13:0] a, input logic [13:0] b, input logic [1:0] pa,
                             input logic [1:0] pb, input int ng, input logic clr_first);
    logic [15:0] wa, wb;
    wa = {a, pa}; wb = {b, pb};
    src_fr = ~src_fr;
    for (int i = 0; i < ng; i++)
      step(src_fr, wa[15 - i*LW -: LW], wb[15 - i*LW -: LW], (i == 0) ? clr_first : 1'b0);
  endtask

  task automatic send_word(input logic [13:0] a, input logic [13:0] b);
    send_word_n(a, b, 2'b00, 2'b00, PW, 1'b0);
  endtask

  task automatic send_rand_words(input int n);
    for (int i = 0; i < n; i++) send_word(14'($urandom), 14'($urandom));
  endtask

  task automatic send_hold(input int ng, input int clr_at);
    for (int i = 0; i < ng; i++)
      step(src_fr, LW'($urandom), LW'($urandom), (i == clr_at) ? 1'b1 : 1'b0);
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    m_reset();
    #1;
    check("rst_lock", 32'(lock_o), 32'h0);
    check("rst_vld", 32'(dat_vld_o), 32'h0);
    check("rst_dat_a", 32'(dat_a_o), 32'h0);
    check("rst_dat_b", 32'(dat_b_o), 32'h0);
    check("rst_err", 32'(err_cnt_o), 32'h0);
    check("rst_pad", 32'(pad_err_o), 32'h0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rstn_i = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever a strobe is due and checks every output each cycle
  always @(negedge clk_i) begin
    bit exp_vld;
    exp_t e;
    exp_vld = (sb_q.size() > 0) && (sb_q[0].due == cyc);
    check("dat_vld", 32'(dat_vld_o), 32'(exp_vld));
    check("sat_vld", 32'(s_vld), 32'(exp_vld));
    if (exp_vld) begin
      e = sb_q.pop_front();
      m_last_a = e.a; m_last_b = e.b;
      check("pad_err", 32'(pad_err_o), 32'(e.pad));
      check("sat_dat_a", 32'(s_dat_a), 32'(e.a));
      check("sat_pad", 32'(s_pad), 32'(e.pad));
    end else begin
      check("pad_idle", 32'(pad_err_o), 32'h0);
    end
    check("dat_a", 32'(dat_a_o), 32'(m_last_a));
    check("dat_b", 32'(dat_b_o), 32'(m_last_b));
    check("lock", 32'(lock_o), 32'(m_mode == M_LOCK));
    check("sat_lock", 32'(s_lock), 32'(m_mode == M_LOCK));
    check("err_cnt", 32'(err_cnt_o), 32'(m_err16));
    check("sat_err", 32'(s_err), 32'(m_err3));
    if (rstn_i && lock_o && lock_rise_cyc < 0) lock_rise_cyc = cyc;
    if (rstn_i && dat_vld_o && first_vld_cyc < 0) begin
      first_vld_cyc = cyc; first_a = dat_a_o; first_b = dat_b_o;
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, r;
    do_reset();
    // Acquisition with the fixed pattern
    send_hold(4, -1);
    t0 = cyc + 1;
    for (int i = 0; i < 6; i++) send_word(14'h2A5B, 14'h1C3F);
    check("lock_rise_edge", 32'(lock_rise_cyc), 32'(t0 + 32));
    check("first_vld_edge", 32'(first_vld_cyc), 32'(t0 + 40));
    check("first_dat_a", 32'(first_a), 32'h2A5B);
    check("first_dat_b", 32'(first_b), 32'h1C3F);
    send_rand_words(10);
    // Frame line stuck: two misses drop lock
    send_hold(2 * PW, -1);
    send_rand_words(6);
    // Extra toggle at group 3, then the source continues on the shifted phase
    send_word_n(14'($urandom), 14'($urandom), 2'b00, 2'b00, 3, 1'b0);
    send_rand_words(7);
    // Non-zero pad bits on lane B
    send_word_n(14'h1234, 14'h0F0F, 2'b00, 2'b01, PW, 1'b0);
    send_word_n(14'h3FFF, 14'h0001, 2'b00, 2'b01, PW, 1'b0);
    // Repeated lock loss drives the narrow counter into saturation
    for (int k = 0; k < 5; k++) begin
      send_hold(2 * PW, -1);
      send_rand_words(6);
    end
    check("sat_saturated", 32'(s_err), 32'h7);
    // Clear coincident with a mismatch
    send_hold(1, 0);
    check("clr_vs_inc", 32'(err_cnt_o), 32'h0);
    check("clr_vs_inc_sat", 32'(s_err), 32'h0);
    send_hold(PW * 2 - 1, -1);
    send_rand_words(6);
    // Asynchronous reset while a strobe is being presented
    send_word_n(14'($urandom), 14'($urandom), 2'b00, 2'b00, 1, 1'b0);
    do_reset();
    // Transition at group 5 during CHECK returns to HUNT without counting an error
    send_hold(4, -1);
    send_word_n(14'($urandom), 14'($urandom), 2'b00, 2'b00, 5, 1'b0);
    send_rand_words(3);
    check("check_fail_err", 32'(err_cnt_o), 32'h0);
    check("check_fail_lock", 32'(lock_o), 32'h0);
    send_rand_words(4);
    // Randomized mix of clean words, glitches, stuck frames and clears
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0)
        send_word_n(14'($urandom), 14'($urandom), 2'b00, 2'b00, $urandom_range(1, PW - 1), 1'b0);
      else if (r == 1)
        send_hold(PW, -1);
      else
        send_word_n(14'($urandom), 14'($urandom),
                    ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00,
                    ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00,
                    PW, ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0);
    end
    send_hold(2, -1);
    @(negedge clk_i);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
